mask_unit_read_xbar_rr: RTL

// - Parametrised, registered successor of the mask-unit read crossbar.
// - Routes NUM_IN read requests to NUM_LANE lane read ports by readLane; tags each with source index (writeIndex).
// - Per-lane round-robin arbitration replaces fixed input priority.
// - One-entry output buffer per lane decouples lane backpressure from the request path.
// - Sits between mask-unit request generators and per-lane VRF read ports.

---
 rtl/mask_unit_read_xbar_rr_if.sv | 38 +++
 rtl/mask_unit_read_xbar_rr.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mask_unit_read_xbar_rr_if.sv
// Request/lane bundle for the mask-unit read crossbar.
// The slave view belongs to the crossbar; master is the surrounding requesters and lanes.
interface mask_unit_read_xbar_rr_if #(
  parameter int NUM_IN   = 4,
  parameter int NUM_LANE = 4,
  parameter int VS_W     = 5,
  parameter int OFFSET_W = 4,
  parameter int DOFF_W   = 2
);
  localparam int LANE_W = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
  localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN-1:0]            in_ready;
  logic [NUM_IN*VS_W-1:0]       in_vs;
  logic [NUM_IN*OFFSET_W-1:0]   in_offset;
  logic [NUM_IN*LANE_W-1:0]     in_read_lane;
  logic [NUM_IN*DOFF_W-1:0]     in_data_offset;
  logic [NUM_LANE-1:0]          out_valid;
  logic [NUM_LANE-1:0]          out_ready;
  logic [NUM_LANE*VS_W-1:0]     out_vs;
  logic [NUM_LANE*OFFSET_W-1:0] out_offset;
  logic [NUM_LANE*IDX_W-1:0]    out_write_index;
  logic [NUM_LANE*DOFF_W-1:0]   out_data_offset;
  logic                         err_bad_lane;

  modport slave (
    input  in_valid, in_vs, in_offset, in_read_lane, in_data_offset, out_ready,
    output in_ready, out_valid, out_vs, out_offset, out_write_index, out_data_offset,
    output err_bad_lane
  );

  modport master (
    output in_valid, in_vs, in_offset, in_read_lane, in_data_offset, out_ready,
    input  in_ready, out_valid, out_vs, out_offset, out_write_index, out_data_offset,
    input  err_bad_lane
  );
endinterface

// File: rtl/mask_unit_read_xbar_rr.sv
// Mask-unit read crossbar: routes requests to lanes with per-lane round-robin
// arbitration and a one-entry registered buffer per lane.
module mask_unit_read_xbar_rr #(
  parameter int NUM_IN   = 4,
  parameter int NUM_LANE = 4,
  parameter int VS_W     = 5,
  parameter int OFFSET_W = 4,
  parameter int DOFF_W   = 2
) (
  input logic clock,
  input logic reset,
  mask_unit_read_xbar_rr_if.slave bus
);
  localparam int LANE_W = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
  localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [IDX_W-1:0]    rrPtr   [NUM_LANE];
  logic [NUM_LANE-1:0] outValid;
  logic [VS_W-1:0]     outVs   [NUM_LANE];
  logic [OFFSET_W-1:0] outOff  [NUM_LANE];
  logic [IDX_W-1:0]    outIdx  [NUM_LANE];
  logic [DOFF_W-1:0]   outDoff [NUM_LANE];
  logic                errBadLane;

  logic [LANE_W-1:0]   laneOf  [NUM_IN];
  logic [NUM_IN-1:0]   laneOk;
  logic [NUM_IN-1:0]   badReq;
  logic [NUM_IN-1:0]   inReady;
  logic [NUM_IN-1:0]   accept;
  logic [NUM_LANE-1:0] canLoad;
  logic [NUM_LANE-1:0] laneLoad;
  logic [IDX_W-1:0]    loadIdx [NUM_LANE];

  // Position of idx in the scan order that starts at ptr.
  function automatic int rotDist(int idx, int ptr);
    return (idx >= ptr) ? (idx - ptr) : (idx - ptr + NUM_IN);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      laneOf[i] = bus.in_read_lane[i*LANE_W +: LANE_W];
      laneOk[i] = int'(laneOf[i]) < NUM_LANE;
      badReq[i] = bus.in_valid[i] && !laneOk[i];
    end
  end

  assign canLoad = ~outValid | bus.out_ready;

  // Input i is ready when it would win its lane if it were requesting, so
  // its own valid never feeds back into its ready.
  always_comb begin
    inReady = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!reset && laneOk[i] && canLoad[laneOf[i]]) begin
        inReady[i] = 1'b1;
        for (int j = 0; j < NUM_IN; j++) begin
          if (j != i && bus.in_valid[j] && laneOf[j] == laneOf[i] &&
              rotDist(j, int'(rrPtr[laneOf[i]])) < rotDist(i, int'(rrPtr[laneOf[i]])))
            inReady[i] = 1'b0;
        end
      end
    end
  end

  assign accept = bus.in_valid & inReady;

  always_comb begin
    laneLoad = '0;
    for (int l = 0; l < NUM_LANE; l++) loadIdx[l] = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (accept[i] && int'(laneOf[i]) == l) begin
          laneLoad[l] = 1'b1;
          loadIdx[l]  = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid   <= '0;
      errBadLane <= 1'b0;
      for (int l = 0; l < NUM_LANE; l++) begin
        rrPtr[l]   <= '0;
        outVs[l]   <= '0;
        outOff[l]  <= '0;
        outIdx[l]  <= '0;
        outDoff[l] <= '0;
      end
    end else begin
      errBadLane <= errBadLane | (|badReq);
      for (int l = 0; l < NUM_LANE; l++) begin
        if (laneLoad[l]) begin
          outValid[l] <= 1'b1;
          outVs[l]    <= bus.in_vs[loadIdx[l]*VS_W +: VS_W];
          outOff[l]   <= bus.in_offset[loadIdx[l]*OFFSET_W +: OFFSET_W];
          outDoff[l]  <= bus.in_data_offset[loadIdx[l]*DOFF_W +: DOFF_W];
          outIdx[l]   <= loadIdx[l];
          rrPtr[l]    <= (int'(loadIdx[l]) == NUM_IN - 1) ? '0 : loadIdx[l] + 1'b1;
        end else if (bus.out_ready[l]) begin
          outValid[l] <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready     = inReady;
  assign bus.out_valid    = outValid;
  assign bus.err_bad_lane = errBadLane;

  always_comb begin
    for (int l = 0; l < NUM_LANE; l++) begin
      bus.out_vs[l*VS_W +: VS_W]                = outVs[l];
      bus.out_offset[l*OFFSET_W +: OFFSET_W]    = outOff[l];
      bus.out_write_index[l*IDX_W +: IDX_W]     = outIdx[l];
      bus.out_data_offset[l*DOFF_W +: DOFF_W]   = outDoff[l];
    end
  end
endmodule
